// File: rtl/fir_stream_pkg.sv
// Shared types, default widths and the output saturate/sign-extend helper for fir_stream_mac.
// Optional feature macro: FIR_STREAM_SATURATE_EN (clamp instead of wrap in ROUND).
package fir_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } fir_state_e;

  localparam int DEF_NUM_TAPS  = 16;
  localparam int DEF_SAMPLE_W  = 16;
  localparam int DEF_COEF_W    = 16;
  localparam int DEF_ACC_W     = 40;
  localparam int DEF_COEF_FRAC = 15;

  // Reduces a scaled accumulator to a w-bit signed sample, sign-extended to 32 bits.
  function automatic logic [31:0] sat_sext(input logic signed [63:0] r, input int w);
    logic signed [63:0] v;
`ifdef FIR_STREAM_SATURATE_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (r > hi) v = hi;
    else if (r < lo) v = lo;
    else v = r;
`else
    v = (r <<< (64 - w)) >>> (64 - w);
`endif
    return v[31:0];
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// NUM_TAPS x COEF_W coefficient register file: one write port, combinational read at the tap index.
module fir_coef_bank
  import fir_stream_pkg::*;
#(
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  parameter int COEF_W   = DEF_COEF_W,
  parameter int IDX_W    = $clog2(NUM_TAPS)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_addr,
  input  logic [COEF_W-1:0]        wr_data,
  input  logic [IDX_W-1:0]         rd_addr,
  output logic signed [COEF_W-1:0] rd_data
);

  logic signed [COEF_W-1:0] coef [NUM_TAPS];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_TAPS; k++) coef[k] <= '0;
    end else if (wr_en) begin
      coef[wr_addr] <= wr_data;
    end
  end

  assign rd_data = coef[rd_addr];

endmodule

// File: rtl/fir_stream_mac.sv
// Time-multiplexed single-MAC FIR: accepts one sample from a read-latency-1 FIFO, runs NUM_TAPS MACs,
// scales/reduces the sum and offers it on a ready-latency-0 stream. Macro: FIR_STREAM_SATURATE_EN.
module fir_stream_mac
  import fir_stream_pkg::*;
#(
  parameter int NUM_TAPS  = DEF_NUM_TAPS,
  parameter int SAMPLE_W  = DEF_SAMPLE_W,
  parameter int COEF_W    = DEF_COEF_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int COEF_FRAC = DEF_COEF_FRAC
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [31:0]                 sink_data,
  input  logic                        sink_valid,
  output logic                        sink_ready,
  output logic [31:0]                 src_data,
  output logic                        src_valid,
  input  logic                        src_ready,
  input  logic [$clog2(NUM_TAPS)-1:0] coef_address,
  input  logic                        coef_write,
  input  logic [31:0]                 coef_writedata,
  output logic                        coef_waitrequest
);

  localparam int IDX_W  = $clog2(NUM_TAPS);
  localparam int PROD_W = SAMPLE_W + COEF_W;

  fir_state_e               state, next_state;
  logic                     ready_q;
  logic                     started;
  logic [IDX_W-1:0]         idx;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_shr;
  logic signed [SAMPLE_W-1:0] x [NUM_TAPS];
  logic signed [COEF_W-1:0] coef_rd;
  logic signed [PROD_W-1:0] prod;
  logic                     last_tap;
  logic                     unused_bits;

  // Upstream FIFO: valid follows a ready pulse by one cycle, so ready pulses every other cycle
  // while idle. started keeps ready low during reset and for the first cycle after it.
  assign sink_ready       = started & (state == IDLE) & !ready_q;
  assign coef_waitrequest = (state != IDLE);
  assign last_tap         = (idx == IDX_W'(NUM_TAPS - 1));
  assign prod             = x[idx] * coef_rd;
  assign acc_shr          = acc >>> COEF_FRAC;
  assign unused_bits      = ^{sink_data[31:SAMPLE_W], coef_writedata[31:COEF_W]};

  fir_coef_bank #(
    .NUM_TAPS (NUM_TAPS),
    .COEF_W   (COEF_W),
    .IDX_W    (IDX_W)
  ) u_coef_bank (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (coef_write & !coef_waitrequest),
    .wr_addr (coef_address),
    .wr_data (coef_writedata[COEF_W-1:0]),
    .rd_addr (idx),
    .rd_data (coef_rd)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (sink_valid) next_state = MAC;
      MAC:     if (last_tap)   next_state = ROUND;
      ROUND:                   next_state = OUT;
      OUT:     if (src_ready)  next_state = IDLE;
      default:                 next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_q   <= 1'b0;
      started   <= 1'b0;
      idx       <= '0;
      acc       <= '0;
      src_data  <= '0;
      src_valid <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) x[k] <= '0;
    end else begin
      ready_q <= sink_ready;
      started <= 1'b1;
      case (state)
        IDLE: begin
          if (sink_valid) begin
            x[0] <= sink_data[SAMPLE_W-1:0];
            for (int k = 1; k < NUM_TAPS; k++) x[k] <= x[k-1];
            acc <= '0;
            idx <= '0;
          end
        end
        MAC: begin
          acc <= acc + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
          idx <= idx + IDX_W'(1);
        end
        ROUND: begin
          src_data  <= sat_sext({{(64 - ACC_W){acc_shr[ACC_W-1]}}, acc_shr}, SAMPLE_W);
          src_valid <= 1'b1;
        end
        OUT: begin
          if (src_ready) src_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
